adc_channel_sched: RTL and testbench

//  Time-shares one delta-tracking loop (shared PWM/RC DAC + analog comparator mux) across NCH channels.
//  Per channel: save/restore the tracked value, wait SETTLE strobes after switching, track for DWELL

---
 rtl/adc_sched_pkg.sv | 36 +++
 rtl/adc_sched_tick.sv | 31 +++
 rtl/adc_channel_sched.sv | 181 ++++++++++++++++++
 tb/tb_adc_channel_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg
//  Shared types and helpers for the channel-multiplexed delta-tracking ADC scheduler.
//  - state_t      : scheduler FSM states
//  - MAX_NCH      : upper bound on channel count accepted by next_enabled()
//  - calc_cw      : channel index width for a given channel count
//  - next_enabled : round-robin search for the next enabled channel
package adc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWITCH = 3'd1,
    S_SETTLE = 3'd2,
    S_TRACK  = 3'd3,
    S_STORE  = 3'd4
  } state_t;

  localparam int MAX_NCH = 32;

  function automatic int calc_cw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Search nch channels starting at index 'start' (mod nch), wrapping once.
  // Returns the first enabled index, or -1 when no channel is enabled.
  function automatic int next_enabled(input logic [MAX_NCH-1:0] en,
                                      input int nch, input int start);
    int idx;
    next_enabled = -1;
    for (int k = 0; k < MAX_NCH; k++) begin
      idx = (start + k) % nch;
      if (k < nch && next_enabled < 0 && en[idx])
        next_enabled = idx;
    end
  endfunction

endpackage

// File: rtl/adc_sched_tick.sv
// adc_sched_tick
//  Free-running strobe divider: one-clock pulse every STROBE_CYCLES clocks,
//  first pulse STROBE_CYCLES clocks after reset release.
// Ports
//  clk     in  system clock
//  reset_n in  asynchronous active-low reset
//  strobe  out sampling strobe
module adc_sched_tick #(
  parameter int STROBE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic strobe
);

  localparam int TW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  logic [TW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == TW'(STROBE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  assign strobe = w_wrap;

endmodule

// File: rtl/adc_channel_sched.sv
// adc_channel_sched
//  Time-shares one delta-tracking loop (shared PWM/RC DAC + comparator mux) across NCH
//  channels. Each slot: restore the channel's tracked value, discard SETTLE strobes,
//  track for DWELL strobes, save the value and publish it on a valid/ready stream.
//  Optional feature macro: ADC_SCHED_OVERRUN_EN
//    undefined : STORE stalls until the result is accepted (backpressure)
//    defined   : STORE never stalls; unaccepted results are overwritten, sticky overrun
// Ports
//  clk, reset_n        clock, asynchronous active-low reset
//  ch_enable           channels in the round-robin
//  comparator_i        per-channel comparator (1 = increase)
//  period_counter_val  PWM period, upper clamp for the tracked value
//  ch_sel              analog mux select
//  on_counter_val      value driving the shared PWM
//  busy                FSM not in IDLE
//  result_valid/ready/data/ch  result stream
//  overrun             sticky lost-result flag (0 unless ADC_SCHED_OVERRUN_EN)
module adc_channel_sched
  import adc_sched_pkg::*;
#(
  parameter  int W             = 16,
  parameter  int NCH           = 4,
  parameter  int STROBE_CYCLES = 16,
  parameter  int DWELL         = 8,
  parameter  int SETTLE        = 2,
  localparam int CW            = calc_cw(NCH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [NCH-1:0] ch_enable,
  input  logic [NCH-1:0] comparator_i,
  input  logic [W-1:0]  period_counter_val,
  output logic [CW-1:0] ch_sel,
  output logic [W-1:0]  on_counter_val,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [W-1:0]  result_data,
  output logic [CW-1:0] result_ch,
  output logic          overrun
);

  localparam int CNTW        = $clog2(((DWELL > SETTLE) ? DWELL : SETTLE) + 1);
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_tgt, w_tgt_val;
  logic [CNTW-1:0]   r_cnt;
  logic [W-1:0]      r_slot [NCH];
  logic [W-1:0]      r_val, r_rdata;
  logic [CW-1:0]     r_sel, r_rch;
  logic              r_rvalid;

  logic              w_strobe;
  logic [MAX_NCH-1:0] w_en_ext;
  int                w_first, w_next;
  logic [W-1:0]      w_val_nxt;
  logic              w_up, w_last, w_xfer, w_leave, w_settle_done;

  adc_sched_tick #(.STROBE_CYCLES(STROBE_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (w_strobe)
  );

  always_comb begin
    w_en_ext = '0;
    w_en_ext[NCH-1:0] = ch_enable;
  end

  // Lowest enabled channel (from IDLE) and next enabled above the current one (from STORE).
  assign w_first = next_enabled(w_en_ext, NCH, 0);
  assign w_next  = next_enabled(w_en_ext, NCH, int'(r_sel) + 1);

  // One tracking step; a value above the period is pulled down to it first.
  assign w_up = comparator_i[r_sel];
  always_comb begin
    w_val_nxt = r_val;
    if (r_val > period_counter_val) w_val_nxt = period_counter_val;
    else if (w_up) begin
      if (r_val < period_counter_val) w_val_nxt = r_val + 1'b1;
    end else if (r_val != '0) w_val_nxt = r_val - 1'b1;
  end

  assign w_settle_done = w_strobe && (r_cnt == CNTW'(SETTLE_LAST));
  assign w_last        = (r_state == S_TRACK) && w_strobe && (r_cnt == CNTW'(DWELL - 1));
  assign w_xfer        = r_rvalid && result_ready;

`ifdef ADC_SCHED_OVERRUN_EN
  assign w_leave = 1'b1;
`else
  assign w_leave = w_xfer;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_val   = r_tgt;
    case (r_state)
      S_IDLE:
        if (w_first >= 0) begin
          w_state_nxt = S_SWITCH;
          w_tgt_val   = CW'(w_first);
        end
      S_SWITCH: w_state_nxt = (SETTLE == 0) ? S_TRACK : S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_nxt = S_TRACK;
      S_TRACK:  if (w_last) w_state_nxt = S_STORE;
      S_STORE:
        if (w_leave) begin
          if (w_next >= 0) begin
            w_state_nxt = S_SWITCH;
            w_tgt_val   = CW'(w_next);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tgt    <= '0;
      r_sel    <= '0;
      r_val    <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rch    <= '0;
      for (int i = 0; i < NCH; i++) r_slot[i] <= '0;
    end else begin
      r_tgt <= w_tgt_val;
      case (r_state)
        S_SWITCH: begin
          r_sel <= r_tgt;
          r_val <= r_slot[r_tgt];
          r_cnt <= '0;
        end
        S_SETTLE:
          if (w_strobe) r_cnt <= w_settle_done ? '0 : r_cnt + 1'b1;
        S_TRACK:
          if (w_strobe) begin
            r_val <= w_val_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        default: ;
      endcase
      // Final step of the dwell: save the slot and publish the result on the same edge.
      if (w_last) begin
        r_slot[r_sel] <= w_val_nxt;
        r_rdata       <= w_val_nxt;
        r_rch         <= r_sel;
      end
      if (w_last)      r_rvalid <= 1'b1;
      else if (w_xfer) r_rvalid <= 1'b0;
    end
  end

`ifdef ADC_SCHED_OVERRUN_EN
  logic r_overrun;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_overrun <= 1'b0;
    else if (w_last && r_rvalid && !result_ready)  r_overrun <= 1'b1;
  end
  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign ch_sel         = r_sel;
  assign on_counter_val = r_val;
  assign busy           = (r_state != S_IDLE);
  assign result_valid   = r_rvalid;
  assign result_data    = r_rdata;
  assign result_ch      = r_rch;

endmodule

// File: tb/tb_adc_channel_sched.sv
module tb_adc_channel_sched;

  localparam int W = 8, NCH = 4, SC = 4, DW = 8, ST = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   ch_enable = '0;
  logic [3:0]   comparator_i = '0;
  logic [7:0]   period_counter_val = 8'd200;
  logic [1:0]   ch_sel;
  logic [7:0]   on_counter_val;
  logic         busy;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [7:0]   result_data;
  logic [1:0]   result_ch;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  adc_channel_sched #(.W(W), .NCH(NCH), .STROBE_CYCLES(SC), .DWELL(DW), .SETTLE(ST)) dut (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .comparator_i(comparator_i),
    .period_counter_val(period_counter_val), .ch_sel(ch_sel), .on_counter_val(on_counter_val),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_ch(result_ch), .overrun(overrun)
  );

  typedef struct {
    logic [3:0] en;
    logic [3:0] cmp;
    logic [7:0] per;
    int         nres;
    logic [1:0] last_ch;
    logic [7:0] last_data;
  } vec_t;

  vec_t vecs[5];

  // Scoreboard: a transfer happens at the next rising edge when valid&&ready here.
  always @(negedge clk) begin
    logic [9:0] exp;
    if (reset_n && result_valid && result_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got ch=%0d data=%0d, none expected", result_ch, result_data);
      end else begin
        exp = sb_q.pop_front();
        if ({result_ch, result_data} !== exp) begin
          n_fail++;
          $display("FAIL result: got ch=%0d data=%0d, expected ch=%0d data=%0d",
                   result_ch, result_data, exp[9:8], exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  // Wait until all expected results were consumed, then stop accepting.
  task automatic drain(input int bound);
    int k = 0;
    while (sb_q.size() != 0 && k < bound) begin step(1); k++; end
    result_ready = 1'b0;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [7:0] model_dwell(input logic [7:0] v0, input logic up,
                                             input logic [7:0] per);
    logic [7:0] v = v0;
    for (int s = 0; s < DW; s++) begin
      if (v > per) v = per;
      else if (up) begin if (v < per) v = v + 8'd1; end
      else if (v != 0) v = v - 8'd1;
    end
    return v;
  endfunction

  function automatic int tb_next_ch(input logic [3:0] en, input int prev);
    int idx;
    for (int k = 1; k <= NCH; k++) begin
      idx = (prev + k) % NCH;
      if (en[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic push_model(input vec_t v);
    logic [7:0] ms [4];
    int prev = NCH - 1;
    int c;
    for (int i = 0; i < NCH; i++) ms[i] = '0;
    for (int r = 0; r < v.nres; r++) begin
      c = tb_next_ch(v.en, prev);
      ms[c] = model_dwell(ms[c], v.cmp[c], v.per);
      sb_q.push_back({2'(c), ms[c]});
      prev = c;
    end
  endtask

  initial begin
    logic [7:0] d0, v0;
    logic [1:0] c0;
    bit         stable;
    int         k;

    vecs[0] = '{4'b0001, 4'b1111, 8'd200, 3, 2'd0, 8'd24};
    vecs[1] = '{4'b1011, 4'b1111, 8'd200, 6, 2'd3, 8'd16};
    vecs[2] = '{4'b0001, 4'b1111, 8'd5,   2, 2'd0, 8'd5};
    vecs[3] = '{4'b0110, 4'b0000, 8'd200, 2, 2'd2, 8'd0};
    vecs[4] = '{4'b1111, 4'b1010, 8'd200, 4, 2'd3, 8'd8};

    // Reset state
    #1;
    chk("rst_ch_sel", 32'(ch_sel), 0);
    chk("rst_on_val", 32'(on_counter_val), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Table-driven vectors, each from a fresh reset
    for (int i = 0; i < 5; i++) begin
      reset_n = 1'b0;
      ch_enable = vecs[i].en;
      comparator_i = vecs[i].cmp;
      period_counter_val = vecs[i].per;
      push_model(vecs[i]);
      result_ready = 1'b1;
      reset_pulse();
      drain(4000);
      chk("vec_last_ch", 32'(result_ch), 32'(vecs[i].last_ch));
      chk("vec_last_data", 32'(result_data), 32'(vecs[i].last_data));
      if (vecs[i].en == 4'b0001) chk("single_ch_sel", 32'(ch_sel), 0);
    end

    // Saturate at period, then walk down to 0 and stay there
    ch_enable = 4'b0001; comparator_i = 4'b1111; period_counter_val = 8'd5;
    reset_pulse();
    sb_q.push_back({2'd0, 8'd5}); sb_q.push_back({2'd0, 8'd5});
    result_ready = 1'b1;
    drain(2000);
    comparator_i = 4'b0000;
    sb_q.push_back({2'd0, 8'd0}); sb_q.push_back({2'd0, 8'd0});
    result_ready = 1'b1;
    drain(2000);

    // Consumer stalled for 200 clocks
    ch_enable = 4'b0001; comparator_i = 4'b1111; period_counter_val = 8'd200;
    reset_pulse();
    k = 0;
    while (!result_valid && k < 500) begin step(1); k++; end
    chk("stall_valid_seen", 32'(result_valid), 1);
    d0 = result_data; c0 = result_ch; v0 = on_counter_val;
    stable = 1'b1;
    repeat (200) begin
      @(negedge clk);
`ifndef ADC_SCHED_OVERRUN_EN
      if (!result_valid || result_data !== d0 || result_ch !== c0 || on_counter_val !== v0)
        stable = 1'b0;
`endif
    end
    step(1);
`ifdef ADC_SCHED_OVERRUN_EN
    chk("ovr_overrun", 32'(overrun), 1);
    chk("ovr_valid", 32'(result_valid), 1);
`else
    chk("stall_stable", 32'(stable), 1);
    chk("stall_data", 32'(d0), 8);
    chk("stall_on_val", 32'(on_counter_val), 8);
    chk("stall_overrun", 32'(overrun), 0);
    sb_q.push_back({2'd0, 8'd8});
    result_ready = 1'b1;
    drain(200);
`endif

    // Reset in the middle of tracking
    ch_enable = 4'b0001; comparator_i = 4'b1111;
    reset_pulse();
    for (int r = 1; r <= 4; r++) sb_q.push_back({2'd0, 8'(8 * r)});
    result_ready = 1'b1;
    drain(4000);
    k = 0;
    while (on_counter_val != 8'd37 && k < 500) begin step(1); k++; end
    chk("midtrack_val", 32'(on_counter_val), 37);
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {ch_sel, on_counter_val, result_valid, result_data, result_ch, busy, overrun}, 0);
    step(2);
    sb_q.push_back({2'd0, 8'd8});
    result_ready = 1'b1;
    reset_n = 1'b1;
    drain(2000);

    // Idle with nothing enabled, then a lone channel 2
    ch_enable = 4'b0000;
    reset_pulse();
    step(20);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ch_sel", 32'(ch_sel), 0);
    ch_enable = 4'b0100;
    step(1);
    chk("wake_busy", 32'(busy), 1);
    step(1);
    chk("wake_ch_sel", 32'(ch_sel), 2);
    sb_q.push_back({2'd2, 8'd8});
    result_ready = 1'b1;
    drain(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
